rf_scoreboard: RTL

- Parametrised successor of the core integer register file, with NRD read ports and NWR write ports.
- Per-port write-to-read bypass; register 0 hardwired to zero.
- Integrated busy-bit scoreboard so the decode stage can see operand readiness and issue legality directly.
- Replaces simulation-only termination with a sticky, synthesizable halt flag raised on a write to HALT_REG.
- Sits between decode (read/issue) and writeback (write) in the pipelined core.

---
 rtl/rf_scoreboard_pkg.sv | 13 +
 rtl/rf_scoreboard_if.sv | 33 +++
 rtl/rf_scoreboard_bypass_mux.sv | 29 ++
 rtl/rf_scoreboard.sv | 98 +++++++++
 4 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Core-wide register-file defaults and packed-bus slicing helpers.
package rf_scoreboard_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREG_DEF     = 32;
    localparam int HALT_REG_DEF = 30;

    // Low bit of field idx in a packed bus of equal-width fields.
    function automatic int field_lo(int idx, int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback side bundle of the scoreboarded register file.
interface rf_scoreboard_if
    import rf_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   w_ra;
    logic [NRD*XLEN-1:0] w_rd;
    logic [NRD-1:0]      w_rdy;
    logic [NWR-1:0]      w_we;
    logic [NWR*AW-1:0]   w_wa;
    logic [NWR*XLEN-1:0] w_wd;
    logic                w_iss_v;
    logic [AW-1:0]       w_iss_a;
    logic                w_iss_ok;
    logic                w_halt;

    modport master (
        output w_ra, w_we, w_wa, w_wd, w_iss_v, w_iss_a,
        input  w_rd, w_rdy, w_iss_ok, w_halt
    );

    modport slave (
        input  w_ra, w_we, w_wa, w_wd, w_iss_v, w_iss_a,
        output w_rd, w_rdy, w_iss_ok, w_halt
    );

endinterface

// File: rtl/rf_scoreboard_bypass_mux.sv
// Per-read-port write bypass; the highest-index matching write port wins.
module rf_bypass_mux
    import rf_scoreboard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]       ra,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Ascending scan so later (higher) ports overwrite earlier matches.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (wa[field_lo(j, AW) +: AW] == ra)) begin
                hit  = 1'b1;
                data = wd[field_lo(j, XLEN) +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-port register file with write bypass, busy-bit scoreboard and sticky halt.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int HALT_REG = HALT_REG_DEF
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    rf_scoreboard_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]     mem [NREG];
    logic [NREG-1:0]     busy;
    logic                halt;
    logic [NWR-1:0]      wr_eff;
    logic                iss_hit;
    logic                halt_hit;
    logic [NRD-1:0]      byp_hit;
    logic [NRD*XLEN-1:0] byp_data;

    // Writes to r0 and writes after halt never commit, bypass or clear busy.
    always_comb begin
        wr_eff   = '0;
        iss_hit  = 1'b0;
        halt_hit = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            wr_eff[j] = bus.w_we[j] && (bus.w_wa[field_lo(j, AW) +: AW] != '0) && !halt;
            if (wr_eff[j] && (bus.w_wa[field_lo(j, AW) +: AW] == bus.w_iss_a))
                iss_hit = 1'b1;
            if (wr_eff[j] && (bus.w_wa[field_lo(j, AW) +: AW] == AW'(HALT_REG)))
                halt_hit = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_byp
        rf_bypass_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_byp (
            .ra   (bus.w_ra[field_lo(gi, AW) +: AW]),
            .wen  (wr_eff),
            .wa   (bus.w_wa),
            .wd   (bus.w_wd),
            .hit  (byp_hit[gi]),
            .data (byp_data[field_lo(gi, XLEN) +: XLEN])
        );
    end

    always_comb begin
        bus.w_rd  = '0;
        bus.w_rdy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.w_ra[field_lo(i, AW) +: AW] == '0)
                bus.w_rd[field_lo(i, XLEN) +: XLEN] = '0;
            else if (byp_hit[i])
                bus.w_rd[field_lo(i, XLEN) +: XLEN] = byp_data[field_lo(i, XLEN) +: XLEN];
            else
                bus.w_rd[field_lo(i, XLEN) +: XLEN] = mem[bus.w_ra[field_lo(i, AW) +: AW]];
            bus.w_rdy[i] = (bus.w_ra[field_lo(i, AW) +: AW] == '0)
                         || !busy[bus.w_ra[field_lo(i, AW) +: AW]]
                         || byp_hit[i];
        end
    end

    // A producer completing this cycle frees its destination for immediate re-issue.
    assign bus.w_iss_ok = bus.w_iss_v && !halt
                       && ((bus.w_iss_a == '0) || !busy[bus.w_iss_a] || iss_hit);
    assign bus.w_halt   = halt;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int k = 0; k < NREG; k++)
                mem[k] <= '0;
            busy <= '0;
            halt <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j]) begin
                    mem[bus.w_wa[field_lo(j, AW) +: AW]]  <= bus.w_wd[field_lo(j, XLEN) +: XLEN];
                    busy[bus.w_wa[field_lo(j, AW) +: AW]] <= 1'b0;
                end
            end
            // Issued after the clear so a same-cycle new producer stays pending.
            if (bus.w_iss_ok && (bus.w_iss_a != '0))
                busy[bus.w_iss_a] <= 1'b1;
            if (halt_hit)
                halt <= 1'b1;
        end
    end

endmodule
